// File: rtl/grf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grf_wb_arbiter_pkg
// Description : Shared types and constants for the GRF writeback arbiter:
//               register-file geometry and the writeback request record used
//               by both the result FIFO and the write-port mux.
// Revision    : 1.0 - initial release
// ============================================================================
package grf_wb_arbiter_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int         GRF_AW   = 5;
   localparam int         XLEN     = 32;

   // One GRF write: destination, data and the PC of the producing instruction
   typedef struct packed {
      logic [GRF_AW-1:0] a3;
      logic [XLEN-1:0]   wd;
      logic [XLEN-1:0]   pc;
   } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/grf_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : grf_wb_fifo
// Description : DEPTH-entry synchronous FIFO of writeback requests. Head is
//               presented combinationally; push is ignored when full and
//               pop is ignored when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_wb_fifo
   import grf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  wb_req_t push_data,
   input  logic    pop,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);

   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];

   wb_req_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grf_wb_arbiter
// Description : Owns the single GRF write port. The W stage always wins;
//               long-latency results bypass when the port and FIFO are free,
//               otherwise queue and drain in order. A pending scoreboard
//               drives the D-stage RAW/WAW stall.
//               Optional: define GRF_WB_STAT_EN to add the stat_preempt
//               counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_wb_arbiter
   import grf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
`ifdef GRF_WB_STAT_EN
   output logic [31:0]       stat_preempt,
`endif
   input  logic              clk,
   input  logic              reset,
   input  logic              w_we,
   input  logic [GRF_AW-1:0] w_a3,
   input  logic [XLEN-1:0]   w_wd,
   input  logic [XLEN-1:0]   w_pc,
   input  logic              lu_valid,
   output logic              lu_ready,
   input  logic [GRF_AW-1:0] lu_a3,
   input  logic [XLEN-1:0]   lu_wd,
   input  logic [XLEN-1:0]   lu_pc,
   input  logic              iss_valid,
   input  logic [GRF_AW-1:0] iss_a3,
   input  logic [GRF_AW-1:0] q_rs,
   input  logic [GRF_AW-1:0] q_rt,
   input  logic [GRF_AW-1:0] q_a3,
   output logic              stall,
   output logic              grf_we,
   output logic [GRF_AW-1:0] grf_a3,
   output logic [XLEN-1:0]   grf_wd,
   output logic [XLEN-1:0]   grf_pc
);

   wb_req_t           fifo_head;
   wb_req_t           lu_req;
   wb_req_t           port_req;
   logic              fifo_full;
   logic              fifo_empty;
   logic              w_claim;
   logic              pop_sel;
   logic              byp_sel;
   logic              lu_xfer;
   logic              fifo_push;
   logic [GRF_AW-1:0] commit_a3;
   logic [31:0]       clr_mask;
   logic [31:0]       set_mask;
   logic [31:0]       pend;

   assign lu_req  = '{a3: lu_a3, wd: lu_wd, pc: lu_pc};

   // A write to register 0 is a non-write, so it leaves the port to the long-latency side
   assign w_claim   = w_we & (w_a3 != REG_ZERO);
   // Ready looks only at the registered full flag, never at lu_valid, to avoid a loop
   assign lu_ready  = reset & ~fifo_full;
   assign lu_xfer   = lu_valid & lu_ready;
   assign pop_sel   = reset & ~w_claim & ~fifo_empty;
   assign byp_sel   = reset & ~w_claim & fifo_empty & lu_valid;
   assign fifo_push = lu_xfer & ~byp_sel;

   grf_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (lu_req),
      .pop       (pop_sel),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Write-port mux: W first, then oldest buffered result, then zero-latency bypass
   always_comb begin
      port_req = '0;
      grf_we   = 1'b0;
      if (!reset) begin
         port_req = '0;
      end else if (w_claim) begin
         port_req = '{a3: w_a3, wd: w_wd, pc: w_pc};
         grf_we   = 1'b1;
      end else if (!fifo_empty) begin
         port_req = fifo_head;
         grf_we   = (fifo_head.a3 != REG_ZERO);
      end else if (lu_valid) begin
         port_req = lu_req;
         grf_we   = (lu_a3 != REG_ZERO);
      end
   end

   assign grf_a3 = port_req.a3;
   assign grf_wd = port_req.wd;
   assign grf_pc = port_req.pc;

   // Long-latency commit clears its pending bit; a fresh issue of the same register wins
   assign commit_a3 = pop_sel ? fifo_head.a3 : lu_a3;
   assign clr_mask  = (pop_sel | byp_sel) ? (32'd1 << commit_a3) : 32'd0;
   assign set_mask  = (iss_valid && iss_a3 != REG_ZERO) ? (32'd1 << iss_a3) : 32'd0;

   // Pending scoreboard; bit 0 is forced clear since register 0 is never written
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= '0;
      end else begin
         pend <= ((pend & ~clr_mask) | set_mask) & ~32'd1;
      end
   end

   // Uses the registered view, so a commit this cycle only unstalls next cycle
   assign stall = pend[q_rs] | pend[q_rt] | pend[q_a3];

`ifdef GRF_WB_STAT_EN
   logic [31:0] preempt_cnt;

   // Count cycles where W took the port while long-latency work was waiting; saturating
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         preempt_cnt <= '0;
      end else if (w_claim && (!fifo_empty || lu_valid) && (preempt_cnt != 32'hFFFF_FFFF)) begin
         preempt_cnt <= preempt_cnt + 32'd1;
      end
   end

   assign stat_preempt = preempt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_grf_wb_arbiter
// Description : Scoreboard bench for grf_wb_arbiter. The driver computes each
//               cycle's expected GRF write from a queue model and pushes it;
//               a negedge monitor pops and compares. lu_ready and stall are
//               checked against the model's occupancy and pending set.
//               Honours GRF_WB_STAT_EN for the stat_preempt output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_wb_arbiter;
   import grf_wb_arbiter_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        w_we = 1'b0, lu_valid = 1'b0, iss_valid = 1'b0;
   logic [4:0]  w_a3 = '0, lu_a3 = '0, iss_a3 = '0, q_rs = '0, q_rt = '0, q_a3 = '0;
   logic [31:0] w_wd = '0, w_pc = '0, lu_wd = '0, lu_pc = '0;
   logic        lu_ready, stall, grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd, grf_pc;
`ifdef GRF_WB_STAT_EN
   logic [31:0] stat_preempt;
`endif

   always #5 clk = ~clk;

   grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
`ifdef GRF_WB_STAT_EN
      .stat_preempt (stat_preempt),
`endif
      .clk       (clk),
      .reset     (reset),
      .w_we      (w_we),
      .w_a3      (w_a3),
      .w_wd      (w_wd),
      .w_pc      (w_pc),
      .lu_valid  (lu_valid),
      .lu_ready  (lu_ready),
      .lu_a3     (lu_a3),
      .lu_wd     (lu_wd),
      .lu_pc     (lu_pc),
      .iss_valid (iss_valid),
      .iss_a3    (iss_a3),
      .q_rs      (q_rs),
      .q_rt      (q_rt),
      .q_a3      (q_a3),
      .stall     (stall),
      .grf_we    (grf_we),
      .grf_a3    (grf_a3),
      .grf_wd    (grf_wd),
      .grf_pc    (grf_pc)
   );

   typedef struct {
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] pc;
   } wr_t;

   wr_t         mq[$];      // buffered long-latency results, oldest first
   wr_t         exp_q[$];   // expected GRF writes awaiting the monitor
   logic [4:0]  iss_q[$];   // issued registers whose result has not been presented
   logic [31:0] pend_m = '0;
   int unsigned preempt_m = 0;
   bit          rand_mode = 0;
   bit          lu_acc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   wr_t         mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      w_we = 0; w_a3 = 0; w_wd = 0; w_pc = 0;
      lu_valid = 0; lu_a3 = 0; lu_wd = 0; lu_pc = 0;
      iss_valid = 0; iss_a3 = 0; q_rs = 0; q_rt = 0; q_a3 = 0;
   endtask

   // Register the long-latency unit will commit this cycle, 0 if none
   function automatic logic [4:0] model_commit_a3();
      if (w_we && w_a3 != 0) return 5'd0;
      if (mq.size() > 0) return mq[0].a3;
      if (lu_valid) return lu_a3;
      return 5'd0;
   endfunction

   // Entered at posedge+2 with inputs applied; leaves at the next posedge+2
   task automatic cycle();
      bit  wclaim, pop, byp, xfer;
      wr_t c;
      logic [4:0] com_a3;
      wclaim = w_we && (w_a3 != 0);
      xfer   = lu_valid && (mq.size() < DEPTH);
      pop = 0; byp = 0; com_a3 = 0;
      if (wclaim) begin
         c = '{w_a3, w_wd, w_pc};
         exp_q.push_back(c);
      end else if (mq.size() > 0) begin
         pop = 1; c = mq[0]; com_a3 = c.a3;
         if (c.a3 != 0) exp_q.push_back(c);
      end else if (lu_valid) begin
         byp = 1; com_a3 = lu_a3;
         c = '{lu_a3, lu_wd, lu_pc};
         if (lu_a3 != 0) exp_q.push_back(c);
      end
      if (wclaim && (mq.size() > 0 || lu_valid)) preempt_m++;
      #1;
      chk("lu_ready", 32'(lu_ready), 32'(mq.size() < DEPTH));
      chk("stall", 32'(stall), 32'(pend_m[q_rs] | pend_m[q_rt] | pend_m[q_a3]));
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (xfer && !byp) begin
         c = '{lu_a3, lu_wd, lu_pc};
         mq.push_back(c);
      end
      if (com_a3 != 0) pend_m[com_a3] = 1'b0;
      if (iss_valid && iss_a3 != 0) begin
         pend_m[iss_a3] = 1'b1;
         if (rand_mode) iss_q.push_back(iss_a3);
      end
      lu_acc = xfer;
      #2;
   endtask

   task automatic issue(input logic [4:0] a);
      idle_inputs();
      iss_valid = 1; iss_a3 = a;
      cycle();
      idle_inputs();
   endtask

   // Monitor: every cycle either the next expected write appears or the port is idle
   always @(negedge clk) begin
      if (reset) begin
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("grf_we", 32'(grf_we), 32'd1);
            chk("grf_a3", 32'(grf_a3), 32'(mon_e.a3));
            chk("grf_wd", grf_wd, mon_e.wd);
            chk("grf_pc", grf_pc, mon_e.pc);
         end else begin
            chk("grf_we_idle", 32'(grf_we), 32'd0);
            chk("grf_a3_idle", 32'(grf_a3), 32'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

   initial begin
      int idx;
      logic [4:0] a;
      idle_inputs();
      // Reset state
      #3;
      chk("rst_grf_we", 32'(grf_we), 32'd0);
      chk("rst_lu_ready", 32'(lu_ready), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      @(posedge clk); @(posedge clk); #2;
      reset = 1;
      #1;
      chk("post_rst_lu_ready", 32'(lu_ready), 32'd1);
      @(posedge clk); #2;

      // Bypass of a pending result; stall holds through the commit cycle
      issue(5'd8);
      lu_valid = 1; lu_a3 = 8; lu_wd = 32'hDEADBEEF; lu_pc = 32'h0000_3000; q_rs = 8;
      cycle();
      idle_inputs(); q_rs = 8;
      cycle();
      idle_inputs();

      // W holds the port for 6 cycles while 5 results arrive
      for (int r = 9; r <= 13; r++) issue(5'(r));
      idx = 0;
      for (int i = 0; i < 12; i++) begin
         w_we = (i < 6); w_a3 = 3; w_wd = $urandom; w_pc = 32'h100 + 32'(i * 4);
         lu_valid = (idx < 5);
         lu_a3 = 5'(9 + idx); lu_wd = 32'hA000_0000 + 32'(idx); lu_pc = 32'h2000 + 32'(idx * 4);
         q_rs = 5'(9 + idx); q_rt = 13;
         cycle();
         if (lu_acc) idx++;
         if (i == 5) chk("accepts_while_w_busy", 32'(idx), 32'd4);
      end
      chk("all_five_accepted", 32'(idx), 32'd5);
      idle_inputs();

      // W request to register 0 is a non-write and lets lu bypass
      issue(5'd4);
      w_we = 1; w_a3 = 0; w_wd = 32'h1111_1111;
      lu_valid = 1; lu_a3 = 4; lu_wd = 32'h4444_4444; lu_pc = 32'h44;
      cycle();
      idle_inputs();
      cycle();

      // Re-issue of a register in the same cycle its older result pops: set wins
      issue(5'd7);
      w_we = 1; w_a3 = 3; w_wd = 32'h3;
      lu_valid = 1; lu_a3 = 7; lu_wd = 32'h7777_7777; lu_pc = 32'h70;
      cycle();
      idle_inputs();
      iss_valid = 1; iss_a3 = 7;
      cycle();
      idle_inputs(); q_a3 = 7;
      cycle();
      idle_inputs();

      // Reset mid-traffic with 3 buffered results and register 5 pending
      issue(5'd5); issue(5'd20); issue(5'd21); issue(5'd22);
      for (int i = 0; i < 3; i++) begin
         w_we = 1; w_a3 = 3; w_wd = $urandom;
         lu_valid = 1; lu_a3 = 5'(20 + i); lu_wd = $urandom; lu_pc = $urandom;
         cycle();
      end
      w_we = 1; w_a3 = 3; lu_valid = 1; q_rs = 5;
      reset = 0;
      #1;
      chk("midrst_grf_we", 32'(grf_we), 32'd0);
      chk("midrst_lu_ready", 32'(lu_ready), 32'd0);
      chk("midrst_stall", 32'(stall), 32'd0);
      mq.delete(); exp_q.delete(); iss_q.delete(); pend_m = '0; preempt_m = 0;
      @(posedge clk); #2;
      idle_inputs(); q_rs = 5;
      reset = 1;
      #1;
      chk("relrst_lu_ready", 32'(lu_ready), 32'd1);
      @(posedge clk); #2;

      // Randomised traffic against the queue model
      rand_mode = 1;
      idle_inputs();
      lu_acc = 0;
      for (int i = 0; i < 1500; i++) begin
         w_we = ($urandom_range(0, 99) < 45);
         w_a3 = 5'($urandom_range(0, 31)); w_wd = $urandom; w_pc = $urandom;
         if (!lu_valid || lu_acc) begin
            lu_valid = 0;
            if (iss_q.size() > 0 && $urandom_range(0, 99) < 60) begin
               lu_valid = 1; lu_a3 = iss_q.pop_front(); lu_wd = $urandom; lu_pc = $urandom;
            end else if ($urandom_range(0, 99) < 5) begin
               lu_valid = 1; lu_a3 = 0; lu_wd = $urandom; lu_pc = $urandom;
            end
         end
         iss_valid = 0; iss_a3 = 0;
         if ($urandom_range(0, 99) < 30) begin
            a = 5'($urandom_range(1, 31));
            if (!pend_m[a] || model_commit_a3() == a) begin
               iss_valid = 1; iss_a3 = a;
            end
         end
         q_rs = 5'($urandom_range(0, 31));
         q_rt = 5'($urandom_range(0, 31));
         q_a3 = 5'($urandom_range(0, 31));
         cycle();
      end
      idle_inputs();
      for (int i = 0; i < 8; i++) cycle();

      chk("model_fifo_drained", 32'(mq.size()), 32'd0);
`ifdef GRF_WB_STAT_EN
      chk("stat_preempt", stat_preempt, preempt_m);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
